// File: rtl/mat_pkg.sv
// mat_pkg: arbiter state encoding and default matrix geometry shared with the matrix-op engines.
package mat_pkg;
    localparam int MAT_DIM_WIDTH  = 3;
    localparam int MAT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } arb_state_e;
endpackage

// File: rtl/mat_rr_pick.sv
// mat_rr_pick: combinational round-robin picker, first requester above last_owner (with wrap) wins.
module mat_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_owner,
    output logic [NUM_REQ-1:0] win
);
    logic [IW-1:0] idx;

    // Descending scan so the nearest requester after last_owner is written last.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(last_owner) + k) % NUM_REQ);
            if (req[idx]) begin
                win      = '0;
                win[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mat_rd_arbiter.sv
// mat_rd_arbiter: round-robin ownership arbiter for the shared matrix storage read port.
// Define MAT_ARB_TIMEOUT_EN to build the S_WAIT watchdog that completes a stalled read with elem=0.
module mat_rd_arbiter
    import mat_pkg::*;
#(
    parameter int DIM_WIDTH      = MAT_DIM_WIDTH,
    parameter int DATA_WIDTH     = MAT_DATA_WIDTH,
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic [NUM_REQ-1:0]            eng_rd_en,
    input  logic [NUM_REQ-1:0]            eng_rd_slot_idx,
    input  logic [NUM_REQ*DIM_WIDTH-1:0]  eng_rd_row_idx,
    input  logic [NUM_REQ*DIM_WIDTH-1:0]  eng_rd_col_idx,
    output logic [DATA_WIDTH-1:0]         eng_rd_elem,
    output logic [NUM_REQ-1:0]            eng_rd_elem_valid,
    output logic                          mem_rd_en,
    output logic                          mem_rd_slot_idx,
    output logic [DIM_WIDTH-1:0]          mem_rd_row_idx,
    output logic [DIM_WIDTH-1:0]          mem_rd_col_idx,
    input  logic [DATA_WIDTH-1:0]         mem_rd_elem,
    input  logic                          mem_rd_elem_valid,
    output logic                          proto_err
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d, pick;
    logic [IW-1:0]        owner_q, owner_d, last_owner_q, last_owner_d, pick_idx;
    logic                 mem_rd_en_q, mem_rd_en_d, slot_q, slot_d, proto_err_q, proto_err_d;
    logic [DIM_WIDTH-1:0] row_q, row_d, col_q, col_d;
    logic                 timeout, ret;

    mat_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .win        (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick[i]) pick_idx = IW'(i);
    end

`ifdef MAT_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_q, wd_d;

    assign timeout = (state_q == S_WAIT) && !mem_rd_elem_valid && (wd_q == WW'(TIMEOUT_CYCLES - 1));
    assign wd_d    = (state_q == S_WAIT && !ret) ? wd_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wd_q <= '0;
        else        wd_q <= wd_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout        = 1'b0;
`endif

    // Returns are only honoured while a read is outstanding; gnt_q doubles as the owner one-hot.
    assign ret               = (state_q == S_WAIT) && (mem_rd_elem_valid || timeout);
    assign eng_rd_elem_valid = ret ? gnt_q : '0;
    assign eng_rd_elem       = timeout ? '0 : mem_rd_elem;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_rd_en_d  = 1'b0;
        slot_d       = slot_q;
        row_d        = row_q;
        col_d        = col_q;
        proto_err_d  = 1'b0;
        case (state_q)
            S_IDLE: if (|req) begin
                gnt_d   = pick;
                owner_d = pick_idx;
                state_d = S_GRANT;
            end
            S_GRANT: if (eng_rd_en[owner_q]) begin
                mem_rd_en_d = 1'b1;
                slot_d      = eng_rd_slot_idx[owner_q];
                row_d       = eng_rd_row_idx[int'(owner_q)*DIM_WIDTH +: DIM_WIDTH];
                col_d       = eng_rd_col_idx[int'(owner_q)*DIM_WIDTH +: DIM_WIDTH];
                state_d     = S_WAIT;
            end else if (!req[owner_q]) begin
                state_d = S_RELEASE;
            end
            S_WAIT: begin
                proto_err_d = eng_rd_en[owner_q] || timeout;
                if (ret) state_d = req[owner_q] ? S_GRANT : S_RELEASE;
            end
            default: begin
                gnt_d        = '0;
                last_owner_d = owner_q;
                state_d      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= IW'(NUM_REQ - 1);
            mem_rd_en_q  <= 1'b0;
            slot_q       <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mem_rd_en_q  <= mem_rd_en_d;
            slot_q       <= slot_d;
            row_q        <= row_d;
            col_q        <= col_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign gnt             = gnt_q;
    assign mem_rd_en       = mem_rd_en_q;
    assign mem_rd_slot_idx = slot_q;
    assign mem_rd_row_idx  = row_q;
    assign mem_rd_col_idx  = col_q;
    assign proto_err       = proto_err_q;
endmodule

// File: doc/mat_rd_arbiter.md
MAT_RD_ARBITER -- requirements
Module: mat_rd_arbiter

Interface
REQ-001 SHALL have parameter DIM_WIDTH, default 3, matrix row/column index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, element width.
REQ-003 SHALL have parameter NUM_REQ, default 3, legal range 2..4, number of matrix-op engines sharing the storage read port.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 15, watchdog limit (used only under REQ-032).
REQ-005 SHALL use one clock and an asynchronous active-low reset, with ports clk and rst_n.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 req  input  NUM_REQ  per-engine ownership request (level; the engine's busy).
REQ-009 gnt  output  NUM_REQ  one-hot ownership grant (registered).
REQ-010 eng_rd_en  input  NUM_REQ  per-engine single-cycle read strobe.
REQ-011 eng_rd_slot_idx  input  NUM_REQ  per-engine slot select.
REQ-012 eng_rd_row_idx, eng_rd_col_idx  input  NUM_REQ*DIM_WIDTH each  flattened per-engine address; engine i occupies bits [i*DIM_WIDTH +: DIM_WIDTH].
REQ-013 eng_rd_elem  output  DATA_WIDTH  returned element, broadcast to all engines.
REQ-014 eng_rd_elem_valid  output  NUM_REQ  per-engine return-valid pulse.
REQ-015 mem_rd_en, mem_rd_slot_idx  output  1 each  storage read strobe and slot (registered).
REQ-016 mem_rd_row_idx, mem_rd_col_idx  output  DIM_WIDTH each  storage address (registered).
REQ-017 mem_rd_elem  input  DATA_WIDTH; mem_rd_elem_valid  input  1  storage return.
REQ-018 proto_err  output  1  single-cycle pulse on an illegal strobe from the owner.

Function
REQ-019 SHALL implement states S_IDLE, S_GRANT, S_WAIT, S_RELEASE.
REQ-020 S_IDLE: any req bit high -> register the round-robin winner into gnt, go to S_GRANT; grant is visible one cycle after req is sampled.
REQ-021 Round robin: the winner is the first requester with req high, searching upward (with wrap) from last_owner+1; last_owner resets to NUM_REQ-1 so engine 0 wins first.
REQ-022 S_GRANT: owner eng_rd_en high -> next cycle mem_rd_en=1 with the owner's slot/row/col; go to S_WAIT.
REQ-023 S_GRANT: owner req low (no strobe) -> S_RELEASE.
REQ-024 S_WAIT: mem_rd_elem_valid -> eng_rd_elem_valid[owner] pulses combinationally in the same cycle, eng_rd_elem=mem_rd_elem; go to S_GRANT, or to S_RELEASE if owner req is low.
REQ-025 S_WAIT: owner eng_rd_en -> strobe ignored, proto_err pulses one cycle later.
REQ-026 S_RELEASE: gnt cleared, last_owner updated, one idle cycle, then S_IDLE; the gap is mandatory even if other requests are pending.
REQ-027 Non-owner eng_rd_en and non-owner req are ignored with no side effect.
REQ-028 mem_rd_elem_valid outside S_WAIT SHALL be dropped; no eng_rd_elem_valid bit asserts.
REQ-029 Owner req dropping in S_WAIT SHALL still complete the read and deliver the valid before release.
REQ-030 mem_rd_en SHALL be a one-cycle pulse, with at most one read outstanding.

Reset
REQ-031 rst_n low SHALL immediately give state S_IDLE, gnt=0, mem_rd_en=0, mem slot/row/col=0, proto_err=0, last_owner=NUM_REQ-1, watchdog=0; eng_rd_elem_valid=0. A read in flight at reset is discarded.

Configuration
REQ-032 Macro MAT_ARB_TIMEOUT_EN defined: a counter runs in S_WAIT; on reaching TIMEOUT_CYCLES with no mem_rd_elem_valid, eng_rd_elem_valid[owner] pulses with eng_rd_elem=0, proto_err pulses, and the FSM proceeds as in REQ-024.
REQ-033 Macro undefined: no counter is built and S_WAIT waits indefinitely.

Structure
REQ-034 Package mat_pkg SHALL hold the arbiter state encoding and default DIM_WIDTH/DATA_WIDTH constants shared with the matrix-op engines.
REQ-035 Sub-module mat_rr_pick (combinational round-robin picker: req, last_owner -> one-hot winner) SHALL be instantiated once.

Verification
REQ-036 Reset, then req=3'b001; engine0 strobes row=2,col=1,slot=1 -> gnt=001 next cycle; mem_rd_en one cycle after strobe with 2/1/1; mem valid data 8'h5A -> eng_rd_elem_valid=001, elem=5A.
REQ-037 req=3'b111 held; each owner does one read then drops req -> grant order 0,1,2,0 with one S_RELEASE idle cycle between grants.
REQ-038 Engine1 strobes again while its read is outstanding -> no second mem_rd_en; proto_err pulses once.
REQ-039 Owner drops req in S_WAIT; mem valid 3 cycles later -> valid delivered to owner, then gnt=0.
REQ-040 With MAT_ARB_TIMEOUT_EN, no mem valid -> after 15 cycles the owner gets valid with elem=0 and proto_err=1; without the macro, gnt is still held at cycle 100.
REQ-041 rst_n asserted in S_WAIT, then a late mem valid arrives -> all outputs at reset values; the valid is dropped.
